// File: rtl/elevador.sv
`default_nettype none
// ============================================================================
// Module      : elevador
// Description : Three-floor elevator controller with Mealy motor commands and
//               an active-low 7-segment floor indicator decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module elevador (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] boton,
    input  logic [3:0] dato,
    output logic       motorsubir,
    output logic       motorbajar,
    output logic [6:0] display
);

    typedef enum logic [1:0] {
        PISO1  = 2'b00,
        PISO2  = 2'b01,
        PISO3  = 2'b10,
        ILEGAL = 2'b11
    } state_t;

    localparam logic [1:0] c_BOTON_SUBIR = 2'b10;
    localparam logic [1:0] c_BOTON_BAJAR = 2'b01;

    state_t r_presente;
    state_t w_futuro;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presente <= PISO1;
        end else begin
            r_presente <= w_futuro;
        end
    end

    // Mealy outputs: motors react to the button in the same cycle it is seen.
    always_comb begin
        w_futuro   = PISO1;
        motorsubir = 1'b0;
        motorbajar = 1'b0;
        case (r_presente)
            PISO1: begin
                if (boton == c_BOTON_SUBIR) begin
                    w_futuro   = PISO2;
                    motorsubir = 1'b1;
                end else begin
                    w_futuro   = PISO1;
                end
            end
            PISO2: begin
                // The middle floor is not a resting position.
                if (boton == c_BOTON_SUBIR) begin
                    w_futuro   = PISO3;
                    motorsubir = 1'b1;
                end else begin
                    w_futuro   = PISO1;
                    motorbajar = 1'b1;
                end
            end
            PISO3: begin
                if (boton == c_BOTON_BAJAR) begin
                    w_futuro   = PISO2;
                    motorbajar = 1'b1;
                end else begin
                    w_futuro   = PISO3;
                end
            end
            default: begin
                w_futuro = PISO1;
            end
        endcase
    end

    always_comb begin
        case (dato)
            4'd1:    display = 7'b1001111;
            4'd2:    display = 7'b0010010;
            4'd3:    display = 7'b0000110;
            default: display = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_elevador.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevador
// Description : Scoreboard bench for the elevator controller and display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevador;

    logic       clk;
    logic       rst_n;
    logic [1:0] boton;
    logic [3:0] dato;
    logic       motorsubir;
    logic       motorbajar;
    logic [6:0] display;

    elevador dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boton      (boton),
        .dato       (dato),
        .motorsubir (motorsubir),
        .motorbajar (motorbajar),
        .display    (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       sub;
        logic       baj;
        logic [1:0] st;
        logic [6:0] disp;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_st;
    int         n_chk;
    int         n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: returns {next[1:0], subir, bajar}.
    function automatic logic [3:0] model_fsm(input logic [1:0] st, input logic [1:0] b);
        case (st)
            2'b00:   model_fsm = (b == 2'b10) ? 4'b01_10 : 4'b00_00;
            2'b01:   model_fsm = (b == 2'b10) ? 4'b10_10 : 4'b00_01;
            2'b10:   model_fsm = (b == 2'b01) ? 4'b01_01 : 4'b10_00;
            default: model_fsm = 4'b00_00;
        endcase
    endfunction

    function automatic logic [6:0] model_disp(input logic [3:0] d);
        case (d)
            4'd1:    model_disp = 7'b1001111;
            4'd2:    model_disp = 7'b0010010;
            4'd3:    model_disp = 7'b0000110;
            default: model_disp = 7'b1111111;
        endcase
    endfunction

    task automatic push_exp(input string tag);
        logic [3:0] r;
        exp_t       e;
        r      = model_fsm(m_st, boton);
        e.tag  = tag;
        e.sub  = r[1];
        e.baj  = r[0];
        e.st   = m_st;
        e.disp = model_disp(dato);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t       e;
        logic [1:0] st;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e  = sb.pop_front();
            st = dut.r_presente;
            chk({e.tag, ".sub"},  {31'd0, motorsubir}, {31'd0, e.sub});
            chk({e.tag, ".baj"},  {31'd0, motorbajar}, {31'd0, e.baj});
            chk({e.tag, ".st"},   {30'd0, st},         {30'd0, e.st});
            chk({e.tag, ".disp"}, {25'd0, display},    {25'd0, e.disp});
        end
    endtask

    task automatic drive(input logic [1:0] b, input logic [3:0] d, input string tag);
        boton = b;
        dato  = d;
        #1;
        push_exp(tag);
        check_out();
    endtask

    task automatic tick();
        logic [3:0] r;
        @(posedge clk);
        if (rst_n) begin
            r    = model_fsm(m_st, boton);
            m_st = r[3:2];
        end
        #2;
    endtask

    initial begin
        logic [1:0] st;
        n_chk  = 0;
        n_pass = 0;
        m_st   = 2'b00;
        rst_n  = 1'b0;
        boton  = 2'b10;
        dato   = 4'd0;
        #1;
        st = dut.r_presente;
        chk("rst_hold0", {30'd0, st}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            st = dut.r_presente;
            chk("rst_hold_edge", {30'd0, st}, 32'd0);
        end

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 4'd1, "rst_idle");
            tick();
        end
        drive(2'b00, 4'd1, "rst_idle_end");

        // Ascend through all floors, then an ignored up request at the top.
        drive(2'b10, 4'd1, "up1");
        tick();
        drive(2'b10, 4'd2, "up2");
        tick();
        drive(2'b10, 4'd3, "up3_ignored");
        tick();
        drive(2'b10, 4'd3, "p3_hold");

        drive(2'b01, 4'd3, "dn1");
        tick();
        drive(2'b01, 4'd2, "dn2");
        tick();
        drive(2'b00, 4'd1, "dn3");
        tick();

        drive(2'b10, 4'd1, "to_p2");
        tick();
        drive(2'b00, 4'd2, "p2_auto");
        tick();
        drive(2'b00, 4'd1, "p2_after");
        drive(2'b11, 4'd1, "p2_code11_prep");
        tick();

        // Climb to the top, then reset asynchronously while descending.
        drive(2'b10, 4'd1, "ar_up1");
        tick();
        drive(2'b10, 4'd2, "ar_up2");
        tick();
        drive(2'b01, 4'd3, "pre_rst");
        rst_n = 1'b0;
        m_st  = 2'b00;
        drive(2'b01, 4'd3, "async_rst");
        rst_n = 1'b1;
        drive(2'b01, 4'd3, "post_rst");
        boton = 2'b00;
        tick();

        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 3) begin
                rst_n = 1'b0;
                m_st  = 2'b00;
            end else begin
                rst_n = 1'b1;
            end
            drive(2'($urandom_range(0, 3)), 4'(i), "disp");
            tick();
        end
        rst_n = 1'b1;

        if (sb.size() != 0) begin
            chk("sb_leftover", sb.size(), 32'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
